// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the DAC waveform sequencer.
// The pass counter is compiled in only when DAC_SEQ_LOOP_EN is defined.
package dac_seq_pkg;

  localparam int          DAC_SEQ_ADDR_W = 10;
  localparam logic [15:0] DAC_MIDSCALE   = 16'h8000;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_ARMED,
    SEQ_PRIME,
    SEQ_RUNNING,
    SEQ_DONE
  } dac_seq_state_t;

endpackage

// File: rtl/dac_seq_ram.sv
// Sample memory: one write port, one registered read port with enable.
// A same-address read and write in one cycle returns the old word.
module dac_seq_ram
  import dac_seq_pkg::*;
#(
  parameter int ADDR_W = DAC_SEQ_ADDR_W,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_o <= mem[rd_addr_i];
  end

endmodule

// File: rtl/dac_waveform_sequencer.sv
// Plays a RAM address range into one DAC channel, one sample per frame strobe.
// Define DAC_SEQ_LOOP_EN to honour loop_count; otherwise one pass per trigger.
module dac_waveform_sequencer
  import dac_seq_pkg::*;
#(
  parameter int          ADDR_W   = DAC_SEQ_ADDR_W,
  parameter logic [15:0] MIDSCALE = DAC_MIDSCALE
) (
  input  logic              dataclk,
  input  logic              reset,
  input  logic              ram_wr_en,
  input  logic [ADDR_W-1:0] ram_wr_addr,
  input  logic [15:0]       ram_wr_data,
  input  logic              seq_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] stop_addr,
  input  logic [15:0]       loop_count,
  input  logic              trigger,
  input  logic              abort,
  input  logic              sample_strobe,
  output logic [15:0]       DAC_sequencer_out,
  output logic              use_sequencer,
  output logic              seq_busy,
  output logic              seq_done
);

  dac_seq_state_t    state_q, state_d;
  logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
  logic [ADDR_W-1:0] startAddr_q, startAddr_d;
  logic [ADDR_W-1:0] stopAddr_q, stopAddr_d;
  logic              finalPass_q, finalPass_d;
  logic              fetch_q, fetch_d;
  logic              trigPrev_q;
  logic [15:0]       dacOut_q, dacOut_d;
  logic              useSeq_q, useSeq_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [15:0]       ramData;
  logic              ramRdEn;
  logic              trigEdge;
  logic              lastPass;

`ifdef DAC_SEQ_LOOP_EN
  logic [15:0] passes_q, passes_d;
  // A latched count of zero never reaches one, so playback repeats until abort.
  assign lastPass = (passes_q == 16'd1);
`else
  logic loop_count_unused;
  assign loop_count_unused = ^loop_count;
  assign lastPass = 1'b1;
`endif

  assign trigEdge = trigger & ~trigPrev_q;
  // Read once in PRIME and once after each consumed strobe, so a later host
  // write to the prefetched address only shows up on the following pass.
  assign ramRdEn  = (state_q == SEQ_PRIME) | fetch_q;

  dac_seq_ram #(.ADDR_W(ADDR_W), .DATA_W(16)) u_ram (
    .clk_i     (dataclk),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (ram_wr_addr),
    .wr_data_i (ram_wr_data),
    .rd_en_i   (ramRdEn),
    .rd_addr_i (rdAddr_q),
    .rd_data_o (ramData)
  );

  always_ff @(posedge dataclk) begin
    if (reset) begin
      state_q     <= SEQ_IDLE;
      rdAddr_q    <= '0;
      startAddr_q <= '0;
      stopAddr_q  <= '0;
      finalPass_q <= 1'b0;
      fetch_q     <= 1'b0;
      trigPrev_q  <= 1'b0;
      dacOut_q    <= MIDSCALE;
      useSeq_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DAC_SEQ_LOOP_EN
      passes_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rdAddr_q    <= rdAddr_d;
      startAddr_q <= startAddr_d;
      stopAddr_q  <= stopAddr_d;
      finalPass_q <= finalPass_d;
      fetch_q     <= fetch_d;
      trigPrev_q  <= trigger;
      dacOut_q    <= dacOut_d;
      useSeq_q    <= useSeq_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DAC_SEQ_LOOP_EN
      passes_q    <= passes_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    rdAddr_d    = rdAddr_q;
    startAddr_d = startAddr_q;
    stopAddr_d  = stopAddr_q;
    finalPass_d = finalPass_q;
    fetch_d     = 1'b0;
`ifdef DAC_SEQ_LOOP_EN
    passes_d    = passes_q;
`endif
    if (!seq_en) begin
      state_d = SEQ_IDLE;
    end else if (abort) begin
      state_d = SEQ_ARMED;
    end else begin
      case (state_q)
        SEQ_IDLE:  state_d = SEQ_ARMED;
        SEQ_ARMED: begin
          if (trigEdge) begin
            state_d     = SEQ_PRIME;
            startAddr_d = start_addr;
            stopAddr_d  = stop_addr;
            rdAddr_d    = start_addr;
            finalPass_d = 1'b0;
`ifdef DAC_SEQ_LOOP_EN
            passes_d    = loop_count;
`endif
          end
        end
        SEQ_PRIME: state_d = SEQ_RUNNING;
        SEQ_RUNNING: begin
          if (sample_strobe) begin
            if (finalPass_q) begin
              state_d = SEQ_DONE;
            end else begin
              fetch_d = 1'b1;
              if (rdAddr_q == stopAddr_q) begin
                rdAddr_d    = startAddr_q;
                finalPass_d = lastPass;
`ifdef DAC_SEQ_LOOP_EN
                if (passes_q > 16'd1) passes_d = passes_q - 16'd1;
`endif
              end else begin
                rdAddr_d = rdAddr_q + ADDR_W'(1);
              end
            end
          end
        end
        SEQ_DONE: state_d = SEQ_ARMED;
        default:  state_d = SEQ_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so nothing is combinational.
  always_comb begin
    dacOut_d = dacOut_q;
    useSeq_d = (state_d == SEQ_RUNNING);
    busy_d   = (state_d == SEQ_PRIME) || (state_d == SEQ_RUNNING);
    done_d   = (state_d == SEQ_DONE);
    if (state_d != SEQ_RUNNING) begin
      dacOut_d = MIDSCALE;
    end else if (state_q == SEQ_RUNNING && sample_strobe) begin
      dacOut_d = ramData;
    end
  end

  assign DAC_sequencer_out = dacOut_q;
  assign use_sequencer     = useSeq_q;
  assign seq_busy          = busy_q;
  assign seq_done          = done_q;

endmodule

// File: tb/tb_dac_waveform_sequencer.sv
// Scoreboard bench for dac_waveform_sequencer; expected samples and done
// events are queued by the stimulus and retired by a separate monitor.
module tb_dac_waveform_sequencer;

  localparam int AW = 4;

  logic          dataclk = 1'b0;
  logic          reset;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [15:0]   ram_wr_data;
  logic          seq_en;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] stop_addr;
  logic [15:0]   loop_count;
  logic          trigger;
  logic          abort;
  logic          sample_strobe;
  logic [15:0]   DAC_sequencer_out;
  logic          use_sequencer;
  logic          seq_busy;
  logic          seq_done;

  typedef struct packed {
    logic        isDone;
    logic [15:0] val;
  } expItem_t;

  expItem_t expQ[$];
  expItem_t monItem;
  int       total = 0;
  int       bad   = 0;
  logic     strobeLast = 1'b0;

  dac_waveform_sequencer #(.ADDR_W(AW), .MIDSCALE(16'h8000)) dut (
    .dataclk           (dataclk),
    .reset             (reset),
    .ram_wr_en         (ram_wr_en),
    .ram_wr_addr       (ram_wr_addr),
    .ram_wr_data       (ram_wr_data),
    .seq_en            (seq_en),
    .start_addr        (start_addr),
    .stop_addr         (stop_addr),
    .loop_count        (loop_count),
    .trigger           (trigger),
    .abort             (abort),
    .sample_strobe     (sample_strobe),
    .DAC_sequencer_out (DAC_sequencer_out),
    .use_sequencer     (use_sequencer),
    .seq_busy          (seq_busy),
    .seq_done          (seq_done)
  );

  always #5 dataclk = ~dataclk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge dataclk);
    #1;
  endtask

  task automatic pushSample(input logic [15:0] v);
    expQ.push_back('{isDone: 1'b0, val: v});
  endtask

  task automatic pushDone();
    expQ.push_back('{isDone: 1'b1, val: 16'h8000});
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      sample_strobe = 1'b1;
      tick();
      sample_strobe = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic writeRam(input logic [AW-1:0] a, input logic [15:0] d);
    ram_wr_en   = 1'b1;
    ram_wr_addr = a;
    ram_wr_data = d;
    tick();
    ram_wr_en   = 1'b0;
  endtask

  // Trigger edge from ARMED, confirming PRIME then RUNNING at midscale.
  task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] e);
    start_addr = s;
    stop_addr  = e;
    trigger    = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    checkOutput("prime_busy", {15'd0, seq_busy}, 16'd1);
    checkOutput("prime_use", {15'd0, use_sequencer}, 16'd0);
    tick();
    trigger = 1'b0;
    checkOutput("run_use", {15'd0, use_sequencer}, 16'd1);
    checkOutput("run_idle_out", DAC_sequencer_out, 16'h8000);
  endtask

  task automatic pushRange25();
    pushSample(16'h1000);
    pushSample(16'h2000);
    pushSample(16'h3000);
    pushSample(16'h4000);
    pushDone();
  endtask

  always @(posedge dataclk) strobeLast <= sample_strobe;

  // Retire one queued expectation per done pulse or per strobe-driven sample.
  always @(negedge dataclk) begin
    if (!reset) begin
      if (seq_done) begin
        if (expQ.size() == 0 || !expQ[0].isDone) begin
          total++;
          bad++;
          $display("[TB] FAIL done_event: got seq_done=1 expected no done (queued=%0d)", expQ.size());
          if (expQ.size() != 0) monItem = expQ.pop_front();
        end else begin
          monItem = expQ.pop_front();
          checkOutput("done_out", DAC_sequencer_out, monItem.val);
          checkOutput("done_use", {15'd0, use_sequencer}, 16'd0);
        end
      end else if (strobeLast && use_sequencer) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL sample_event: got sample %h expected none", DAC_sequencer_out);
        end else begin
          monItem = expQ.pop_front();
          if (monItem.isDone) begin
            total++;
            bad++;
            $display("[TB] FAIL sample_event: got sample %h expected done", DAC_sequencer_out);
          end else begin
            checkOutput("sample", DAC_sequencer_out, monItem.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; ram_wr_en = 1'b0; ram_wr_addr = '0; ram_wr_data = '0;
    seq_en = 1'b0; start_addr = '0; stop_addr = '0; loop_count = 16'd1;
    trigger = 1'b0; abort = 1'b0; sample_strobe = 1'b0;
    repeat (3) tick();
    checkOutput("rst_out", DAC_sequencer_out, 16'h8000);
    checkOutput("rst_use", {15'd0, use_sequencer}, 16'd0);
    checkOutput("rst_busy", {15'd0, seq_busy}, 16'd0);
    checkOutput("rst_done", {15'd0, seq_done}, 16'd0);
    reset = 1'b0;
    tick();

    writeRam(4'd2, 16'h1000);
    writeRam(4'd3, 16'h2000);
    writeRam(4'd4, 16'h3000);
    writeRam(4'd5, 16'h4000);
    writeRam(4'd14, 16'hE0E0);
    writeRam(4'd15, 16'hF0F0);
    writeRam(4'd0, 16'h0A0A);
    writeRam(4'd1, 16'h0B0B);

    seq_en = 1'b1;
    tick();

    $display("[TB] single pass");
    applyStimulus(4'd2, 4'd5);
    pushRange25();
    strobes(5);
    checkOutput("after_done_busy", {15'd0, seq_busy}, 16'd0);

    $display("[TB] wrap");
    applyStimulus(4'd14, 4'd1);
    pushSample(16'hE0E0); pushSample(16'hF0F0);
    pushSample(16'h0A0A); pushSample(16'h0B0B);
    pushDone();
    strobes(5);

    $display("[TB] loop count 3");
    loop_count = 16'd3;
    applyStimulus(4'd2, 4'd3);
`ifdef DAC_SEQ_LOOP_EN
    for (int i = 0; i < 3; i++) begin
      pushSample(16'h1000);
      pushSample(16'h2000);
    end
    pushDone();
    strobes(7);
    $display("[TB] loop count 0");
    loop_count = 16'd0;
    applyStimulus(4'd2, 4'd3);
    for (int i = 0; i < 100; i++) pushSample(i[0] ? 16'h2000 : 16'h1000);
    strobes(100);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("inf_abort_use", {15'd0, use_sequencer}, 16'd0);
`else
    pushSample(16'h1000);
    pushSample(16'h2000);
    pushDone();
    strobes(3);
`endif
    loop_count = 16'd1;

    $display("[TB] abort");
    applyStimulus(4'd2, 4'd5);
    pushSample(16'h1000);
    pushSample(16'h2000);
    strobes(2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_use", {15'd0, use_sequencer}, 16'd0);
    checkOutput("abort_out", DAC_sequencer_out, 16'h8000);
    checkOutput("abort_busy", {15'd0, seq_busy}, 16'd0);
    checkOutput("abort_done", {15'd0, seq_done}, 16'd0);
    applyStimulus(4'd2, 4'd5);
    pushRange25();
    strobes(5);

    $display("[TB] reset while running");
    applyStimulus(4'd2, 4'd5);
    pushSample(16'h1000);
    strobes(1);
    reset = 1'b1;
    tick();
    checkOutput("midrst_out", DAC_sequencer_out, 16'h8000);
    checkOutput("midrst_use", {15'd0, use_sequencer}, 16'd0);
    checkOutput("midrst_busy", {15'd0, seq_busy}, 16'd0);
    checkOutput("midrst_done", {15'd0, seq_done}, 16'd0);
    reset = 1'b0;
    tick();
    applyStimulus(4'd2, 4'd5);
    pushRange25();
    strobes(5);

    $display("[TB] trigger with strobe");
    start_addr = 4'd2;
    stop_addr  = 4'd5;
    trigger    = 1'b0;
    tick();
    trigger       = 1'b1;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
    checkOutput("trgstb_busy", {15'd0, seq_busy}, 16'd1);
    checkOutput("trgstb_use", {15'd0, use_sequencer}, 16'd0);
    checkOutput("trgstb_out", DAC_sequencer_out, 16'h8000);
    tick();
    trigger = 1'b0;
    checkOutput("trgstb_run", {15'd0, use_sequencer}, 16'd1);
    pushRange25();
    strobes(5);

    $display("[TB] write during prefetch");
    start_addr = 4'd2;
    stop_addr  = 4'd3;
    trigger    = 1'b0;
    tick();
    trigger = 1'b1;
    tick();
    ram_wr_en   = 1'b1;
    ram_wr_addr = 4'd2;
    ram_wr_data = 16'h5555;
    tick();
    ram_wr_en = 1'b0;
    trigger   = 1'b0;
    pushSample(16'h1000);
    pushSample(16'h2000);
    pushDone();
    strobes(3);
    applyStimulus(4'd2, 4'd3);
    pushSample(16'h5555);
    pushSample(16'h2000);
    pushDone();
    strobes(3);

    repeat (4) tick();
    checkOutput("queue_empty", 16'(expQ.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_waveform_sequencer.md
# dac_waveform_sequencer

Per-DAC waveform playback controller that drives the `DAC_sequencer_in` / `use_sequencer` inputs of one scalable-HPF DAC output channel. Host writes 16-bit offset-binary samples into a local RAM. After arming and a trigger, the block plays a programmed address range, one sample per sample-frame strobe. It takes over the DAC register only while playing and otherwise hands it back to the amplifier path.

## Interface
Parameters:
- `ADDR_W`, 10: RAM address width; depth = 2^ADDR_W words.
- `MIDSCALE`, 16'h8000: idle output code (0 V).

Ports:
- `dataclk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `ram_wr_en`  in  1  host write strobe.
- `ram_wr_addr`  in  ADDR_W  host write address.
- `ram_wr_data`  in  16  offset-binary sample.
- `seq_en`  in  1  enable; low forces IDLE (acts as abort).
- `start_addr`, `stop_addr`  in  ADDR_W  inclusive playback range; sampled at trigger.
- `loop_count`  in  16  passes to play, 0 = infinite (DAC_SEQ_LOOP_EN only).
- `trigger`  in  1  level input; rising edge starts playback.
- `abort`  in  1  one-cycle stop request.
- `sample_strobe`  in  1  one-cycle pulse per sample frame; spacing ≥4 cycles guaranteed.
- `DAC_sequencer_out`  out  16  sample to DAC register.
- `use_sequencer`  out  1  high while RUNNING.
- `seq_busy`  out  1  high in PRIME/RUNNING.
- `seq_done`  out  1  one-cycle pulse at natural end of playback.

## Operation
- States: IDLE, ARMED, PRIME, RUNNING, DONE.
- IDLE: `seq_en`=0. Go to ARMED when `seq_en`=1.
- ARMED: wait for a trigger rising edge (registered previous value; trigger high at arming time is not an edge). On edge: latch start/stop/loop_count, set rd_addr=start_addr, go to PRIME.
- PRIME: one cycle for the RAM read. Go to RUNNING.
- RUNNING, each `sample_strobe`:
  - `DAC_sequencer_out` ← prefetched mem[rd_addr].
  - If rd_addr==stop_addr, end of pass: reload start_addr.
  - Otherwise rd_addr+1, wrapping 2^ADDR_W−1→0, so stop<start plays through the wrap.
  - start==stop plays one sample per pass.
- End of final pass: the last sample is held for its frame. The next strobe moves the state to DONE.
- DONE: one cycle. `seq_done`=1, `DAC_sequencer_out`=MIDSCALE, `use_sequencer`=0. Go to ARMED if `seq_en`, else IDLE.
- Abort: `abort` or `seq_en`=0 in any state sends the block to ARMED or IDLE respectively next cycle. Output returns to MIDSCALE, no `seq_done`.
- Priority: reset > abort/`seq_en` low > trigger > sample_strobe.
  - Trigger and strobe in the same ARMED cycle: trigger taken, strobe ignored.
  - Trigger while PRIME/RUNNING/DONE: ignored and not queued.
- RAM: host writes are allowed in any state. A read and a write to the same address in the same cycle return the old data. Reset does not clear RAM.

## Timing
- Reset values: `DAC_sequencer_out`=MIDSCALE, `use_sequencer`=0, `seq_busy`=0, `seq_done`=0, state IDLE.
- Trigger edge at cycle T → PRIME at T+1 → RUNNING at T+2. `use_sequencer` rises at T+2 and shows MIDSCALE until the first strobe.
- Strobe at cycle S → new `DAC_sequencer_out` visible at S+1; next prefetch valid by S+2.
- All outputs registered; no combinational input→output paths.

## Configuration
- `DAC_SEQ_LOOP_EN` defined:
  - `loop_count` is honoured; a pass counter is decremented at each end of pass.
  - DONE after `loop_count` passes.
  - 0 = repeat until abort.
- `DAC_SEQ_LOOP_EN` not defined: `loop_count` is ignored, and exactly one pass is played per trigger.

## Structure
- Package `dac_seq_pkg`: state enum `dac_seq_state_t`, `DAC_MIDSCALE` constant, default `ADDR_W`.
- Sub-module `dac_seq_ram`: simple dual-port RAM, one write port, one registered read port, read-old-on-collision. Infers block RAM.

## Test plan
- Single pass: write 0x1000,0x2000,0x3000,0x4000 at addr 2–5; start=2, stop=5; trigger → on 4 strobes the output is 0x1000…0x4000. The 5th strobe gives DONE, `seq_done` pulse, output 0x8000.
- Wrap: ADDR_W=4, start=14, stop=1 → plays addr 14,15,0,1, then DONE.
- Loop (macro on): loop_count=3, range 2–3 → 6 samples, then one `seq_done`. loop_count=0 plays 100 strobes with no done. Macro off: the same stimulus gives 2 samples.
- Abort mid-run after 2 strobes → next cycle `use_sequencer`=0, output 0x8000, no `seq_done`, state ARMED. A new trigger edge restarts from start_addr.
- Reset asserted in RUNNING → all outputs at reset values next cycle. RAM contents intact on replay.
- Collisions:
  - Trigger + strobe in the same cycle → PRIME, no sample emitted.
  - Host write to the current rd_addr during prefetch → old value played this pass, new value next pass.
